operand_forward_ctrl: RTL and testbench

//  Hazard/forwarding controller for the 16-bit pipeline. Tracks destination registers through the
//  EX, MEM and WB stages. Drives the 2-bit selects of the two 3:1 ALU-operand muxes that sit

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_sel_cmp.sv | 41 ++++
 rtl/operand_forward_ctrl.sv | 89 ++++++++
 tb/tb_operand_forward_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and mux-select codes for the operand forwarding controller.
// Stage bundles carry just enough state to resolve RAW hazards.
package fwd_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // rd is sized for the widest register file we build
  localparam int RD_W = 8;

  typedef struct packed {
    logic            valid;
    logic            wr_en;
    logic            is_load;
    logic [RD_W-1:0] rd;
  } stage_ctl_t;

endpackage

// File: rtl/fwd_sel_cmp.sv
// Single-operand forward select: youngest non-load producer wins.
// A load sitting in MEM has no data yet, so only WB may satisfy it.
module fwd_sel_cmp
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter bit R0_ZERO = 1'b0
) (
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] rs,
  input  stage_ctl_t        mem,
  input  stage_ctl_t        wb,
  output logic [1:0]        sel
);

  logic rs_zero;
  logic mem_hit;
  logic wb_hit;
  logic unused_wb_ld;

  assign rs_zero = R0_ZERO && (rs == '0);

  assign mem_hit = mem.valid & mem.wr_en & ~mem.is_load
                 & (mem.rd == RD_W'(rs)) & ~rs_zero;

  assign wb_hit = wb.valid & wb.wr_en
                & (wb.rd == RD_W'(rs)) & ~rs_zero;

  assign unused_wb_ld = wb.is_load;

  always_comb begin
    sel = FWD_RF;
    if (!ex_valid)
      sel = FWD_RF;
    else if (mem_hit)
      sel = FWD_MEM;
    else if (wb_hit)
      sel = FWD_WB;
  end

endmodule

// File: rtl/operand_forward_ctrl.sv
// Tracks EX/MEM/WB destinations, drives ALU operand forward selects,
// and stalls one cycle on a load-use hazard.
module operand_forward_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter bit R0_ZERO = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              ex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_ctl_t        ex_q;
  stage_ctl_t        mem_q;
  stage_ctl_t        wb_q;
  logic [REG_AW-1:0] ex_rs1_q;
  logic [REG_AW-1:0] ex_rs2_q;
  logic              use1;
  logic              use2;

  assign use1 = (ex_q.rd == RD_W'(id_rs1))
              && !(R0_ZERO && (id_rs1 == '0));
  assign use2 = (ex_q.rd == RD_W'(id_rs2))
              && !(R0_ZERO && (id_rs2 == '0));

  assign stall = id_valid & ex_q.valid & ex_q.is_load
               & ex_q.wr_en & (use1 | use2);

  // flush also kills EX; suppressed while reset holds
  assign ex_bubble = ~rst & (stall | flush);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      stall_cnt <= '0;
    end else begin
      ex_q.valid   <= id_valid & ~stall & ~flush;
      ex_q.wr_en   <= id_wr_en;
      ex_q.is_load <= id_is_load;
      ex_q.rd      <= RD_W'(id_rd);
      ex_rs1_q     <= id_rs1;
      ex_rs2_q     <= id_rs2;
      mem_q        <= ex_q;
      wb_q         <= mem_q;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  fwd_sel_cmp #(
    .REG_AW  (REG_AW),
    .R0_ZERO (R0_ZERO)
  ) u_cmp_a (
    .ex_valid (ex_q.valid),
    .rs       (ex_rs1_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_a_sel)
  );

  fwd_sel_cmp #(
    .REG_AW  (REG_AW),
    .R0_ZERO (R0_ZERO)
  ) u_cmp_b (
    .ex_valid (ex_q.valid),
    .rs       (ex_rs2_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .sel      (fwd_b_sel)
  );

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Bench for operand_forward_ctrl: directed scenarios plus random traffic
// against an instruction-level model, on an R0-ordinary and an R0-zero build.
module tb_operand_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic       id_wr_en = 1'b0;
  logic       id_is_load = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] id_rs1 = '0;
  logic [3:0] id_rs2 = '0;
  logic [3:0] id_rd = '0;

  logic [1:0]  sa [2];
  logic [1:0]  sb [2];
  logic        st [2];
  logic        bb [2];
  logic [15:0] c0;
  logic [1:0]  c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_forward_ctrl #(.REG_AW(4), .R0_ZERO(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .fwd_a_sel(sa[0]),
    .fwd_b_sel(sb[0]), .stall(st[0]), .ex_bubble(bb[0]), .stall_cnt(c0)
  );

  operand_forward_ctrl #(.REG_AW(4), .R0_ZERO(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_is_load(id_is_load), .flush(flush), .fwd_a_sel(sa[1]),
    .fwd_b_sel(sb[1]), .stall(st[1]), .ex_bubble(bb[1]), .stall_cnt(c1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit v; int rd; bit wr; bit ld; int rs1; int rs2;
  } ins_t;

  ins_t ex_m [2];
  ins_t mem_m [2];
  ins_t wb_m [2];
  int   cnt_m [2];
  int   cmax [2] = '{65535, 3};
  bit   r0z [2] = '{1'b0, 1'b1};

  function automatic bit reads(int m, int rd, int rs);
    return (rd == rs) && !(r0z[m] && rs == 0);
  endfunction

  function automatic bit writes(int m, ins_t s, int rs);
    return s.v && s.wr && reads(m, s.rd, rs);
  endfunction

  // load results exist only once the load reaches WB
  function automatic int exp_sel(int m, int rs);
    if (!ex_m[m].v) return 0;
    if (writes(m, mem_m[m], rs) && !mem_m[m].ld) return 1;
    if (writes(m, wb_m[m], rs)) return 2;
    return 0;
  endfunction

  function automatic bit exp_stall(int m);
    ins_t e = ex_m[m];
    if (!(id_valid && e.v && e.ld && e.wr)) return 1'b0;
    return reads(m, e.rd, int'(id_rs1)) || reads(m, e.rd, int'(id_rs2));
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      ex_m[m] = '{0, 0, 0, 0, 0, 0};
      mem_m[m] = '{0, 0, 0, 0, 0, 0};
      wb_m[m] = '{0, 0, 0, 0, 0, 0};
      cnt_m[m] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int m = 0; m < 2; m++) begin
      bit s = exp_stall(m);
      if (s && cnt_m[m] < cmax[m]) cnt_m[m]++;
      wb_m[m] = mem_m[m];
      mem_m[m] = ex_m[m];
      ex_m[m] = '{id_valid && !s && !flush, int'(id_rd), id_wr_en,
                  id_is_load, int'(id_rs1), int'(id_rs2)};
    end
  endfunction

  // a load in MEM must never be the only source for the EX instruction
  always @(negedge clk) begin
    if (!rst && dut0.ex_q.valid && dut0.mem_q.valid
        && dut0.mem_q.is_load && dut0.mem_q.wr_en) begin
      assert (dut0.mem_q.rd != 8'(dut0.ex_rs1_q)
           && dut0.mem_q.rd != 8'(dut0.ex_rs2_q))
      else begin
        errors++;
        $error("FAIL load_in_mem rd %0d ex_rs %0d/%0d",
               dut0.mem_q.rd, dut0.ex_rs1_q, dut0.ex_rs2_q);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(bit v, int rs1, int rs2, int rd,
                       bit wr, bit ld, bit fl);
    id_valid = v;
    id_rs1 = 4'(rs1);
    id_rs2 = 4'(rs2);
    id_rd = 4'(rd);
    id_wr_en = wr;
    id_is_load = ld;
    flush = fl;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    flush = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (sa[m] !== 2'b00 || sb[m] !== 2'b00) begin
        errors++;
        $display("FAIL reset_sel dut%0d got %b/%b exp 00/00", m, sa[m], sb[m]);
      end
      checks++;
      if (st[m] !== 1'b0 || bb[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall dut%0d got %b/%b exp 0/0", m, st[m], bb[m]);
      end
    end
    checks++;
    if (c0 !== 16'd0 || c1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0", c0, c1);
    end
    flush = 1'b0;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    drain();
    drive(1, 1, 2, 3, 1, 0, 0);
    tick();
    drive(1, 3, 4, 5, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (sa[m] !== 2'b01 || sb[m] !== 2'b00) begin
        errors++;
        $display("FAIL b2b_sel dut%0d got %b/%b exp 01/00", m, sa[m], sb[m]);
      end
    end
    tick();
  endtask

  task automatic test_two_ahead();
    drain();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 7, 8, 6, 1, 0, 0);
    tick();
    drive(1, 5, 5, 9, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (sa[0] !== 2'b10 || sb[0] !== 2'b10) begin
      errors++;
      $display("FAIL wb_fwd got %b/%b exp 10/10", sa[0], sb[0]);
    end
    tick();
    drain();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 5, 5, 9, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (sa[0] !== 2'b01 || sb[0] !== 2'b01) begin
      errors++;
      $display("FAIL mem_prio got %b/%b exp 01/01", sa[0], sb[0]);
    end
    tick();
  endtask

  task automatic test_load_use();
    int base;
    drain();
    base = cnt_m[0];
    drive(1, 1, 1, 2, 1, 1, 0);
    tick();
    drive(1, 2, 9, 7, 1, 0, 0);
    checks++;
    if (st[0] !== 1'b1 || bb[0] !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b/%b exp 1/1", st[0], bb[0]);
    end
    checks++;
    if (c0 !== 16'(base)) begin
      errors++;
      $display("FAIL lu_cnt_before got %0d exp %0d", c0, base);
    end
    tick();
    drive(1, 2, 9, 7, 1, 0, 0);
    checks++;
    if (st[0] !== 1'b0 || c0 !== 16'(base + 1)) begin
      errors++;
      $display("FAIL lu_release got %b/%0d exp 0/%0d", st[0], c0, base + 1);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (sa[0] !== 2'b10 || sb[0] !== 2'b00) begin
      errors++;
      $display("FAIL lu_fwd got %b/%b exp 10/00", sa[0], sb[0]);
    end
    tick();
  endtask

  task automatic test_flush_stall();
    int base;
    drain();
    base = cnt_m[0];
    drive(1, 1, 1, 2, 1, 1, 0);
    tick();
    drive(1, 2, 3, 4, 1, 0, 1);
    checks++;
    if (st[0] !== 1'b1 || bb[0] !== 1'b1) begin
      errors++;
      $display("FAIL fl_bubble got %b/%b exp 1/1", st[0], bb[0]);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (dut0.ex_q.valid !== 1'b0 || c0 !== 16'(base + 1)) begin
      errors++;
      $display("FAIL fl_ex got valid %b cnt %0d exp 0/%0d",
               dut0.ex_q.valid, c0, base + 1);
    end
    tick();
  endtask

  task automatic test_r0_zero();
    drain();
    drive(1, 1, 2, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 5, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (sa[1] !== 2'b00 || sb[1] !== 2'b00) begin
      errors++;
      $display("FAIL r0_sel got %b/%b exp 00/00", sa[1], sb[1]);
    end
    checks++;
    if (sa[0] !== 2'b01 || sb[0] !== 2'b01) begin
      errors++;
      $display("FAIL r0_ordinary got %b/%b exp 01/01", sa[0], sb[0]);
    end
    tick();
    drain();
    drive(1, 1, 1, 0, 1, 1, 0);
    tick();
    drive(1, 0, 3, 6, 1, 0, 0);
    checks++;
    if (st[1] !== 1'b0 || st[0] !== 1'b1) begin
      errors++;
      $display("FAIL r0_stall got %b/%b exp 0/1", st[1], st[0]);
    end
    tick();
    nop();
  endtask

  task automatic test_saturate();
    drain();
    for (int k = 0; k < 5; k++) begin
      drive(1, 2, 2, 1, 1, 1, 0);
      tick();
      drive(1, 1, 3, 4, 1, 0, 0);
      tick();
      nop();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (c1 !== 2'd3) begin
      errors++;
      $display("FAIL sat_cnt got %0d exp 3", c1);
    end
    checks++;
    if (c0 !== 16'(cnt_m[0])) begin
      errors++;
      $display("FAIL sat_cnt16 got %0d exp %0d", c0, cnt_m[0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9) < 8, $urandom_range(3), $urandom_range(3),
            $urandom_range(3), $urandom_range(9) < 8,
            $urandom_range(9) < 3, $urandom_range(9) == 0);
      for (int m = 0; m < 2; m++) begin
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       eu;
        int         oc;
        ea = 2'(exp_sel(m, ex_m[m].rs1));
        eb = 2'(exp_sel(m, ex_m[m].rs2));
        es = exp_stall(m);
        eu = es | flush;
        oc = (m == 0) ? int'(c0) : int'(c1);
        checks++;
        if (sa[m] !== ea) begin
          errors++;
          $display("FAIL rnd_a dut%0d cyc %0d got %b exp %b", m, i, sa[m], ea);
        end
        checks++;
        if (sb[m] !== eb) begin
          errors++;
          $display("FAIL rnd_b dut%0d cyc %0d got %b exp %b", m, i, sb[m], eb);
        end
        checks++;
        if (st[m] !== es) begin
          errors++;
          $display("FAIL rnd_stall dut%0d cyc %0d got %b exp %b", m, i, st[m], es);
        end
        checks++;
        if (bb[m] !== eu) begin
          errors++;
          $display("FAIL rnd_bubble dut%0d cyc %0d got %b exp %b", m, i, bb[m], eu);
        end
        checks++;
        if (oc != cnt_m[m]) begin
          errors++;
          $display("FAIL rnd_cnt dut%0d cyc %0d got %0d exp %0d", m, i, oc, cnt_m[m]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(1, 1, 1, 2, 1, 1, 0);
    tick();
    drive(1, 2, 3, 4, 1, 0, 0);
    checks++;
    if (st[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_stall got %b exp 1", st[0]);
    end
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (st[0] !== 1'b0 || bb[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stall got %b/%b exp 0/0", st[0], bb[0]);
    end
    checks++;
    if (sa[0] !== 2'b00 || sb[0] !== 2'b00 || c0 !== 16'd0 || c1 !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_clear got %b/%b/%0d/%0d exp 00/00/0/0",
               sa[0], sb[0], c0, c1);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    tick();
    nop();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_two_ahead();
    test_load_use();
    test_flush_stall();
    test_r0_zero();
    test_saturate();
    test_random();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
